// File: rtl/jshift_register.sv
// Bidirectional shift register with rotate, parallel load, tristate output,
// a saturating shift counter and a word-complete pulse.
module jshift_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         rot,
  input  logic                         sin_l,
  input  logic                         sin_r,
  input  logic [WIDTH-1:0]             d,
  input  logic                         oe,
  output logic [WIDTH-1:0]             q,
  output logic                         sout,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         word_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;
  logic [CW-1:0]    cnt_inc;

  assign cnt_inc = (cnt_q == CMAX) ? CMAX : cnt_q + 1'b1;

  always_comb begin
    reg_d  = reg_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (en) begin
      unique case (mode)
        2'b01: begin
          reg_d  = {rot ? reg_q[0] : sin_l, reg_q[WIDTH-1:1]};
          sout_d = reg_q[0];
          shift  = 1'b1;
        end
        2'b10: begin
          reg_d  = {reg_q[WIDTH-2:0], rot ? reg_q[WIDTH-1] : sin_r};
          sout_d = reg_q[WIDTH-1];
          shift  = 1'b1;
        end
        2'b11: begin
          reg_d = d;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    if (shift) begin
      cnt_d  = cnt_inc;
      // pulse only on the transition into a full word
      done_d = (cnt_q == CMAX - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q  <= RESET_VALUE;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = oe ? reg_q : {WIDTH{1'bz}};
  assign sout      = sout_q;
  assign cnt       = cnt_q;
  assign word_done = done_q;

endmodule

// File: tb/tb_jshift_register.sv
// Directed + random bench for jshift_register with a queued
// expected-result scoreboard and a behavioural reference model.
module tb_jshift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en, rot, sin_l, sin_r, oe;
  logic [1:0]   mode;
  logic [W-1:0] d;
  wire  [W-1:0] q;
  logic         sout, word_done;
  logic [3:0]   cnt;

  int checks = 0;
  int fails  = 0;
  int pulses = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         so;
    logic [3:0]   c;
    logic         wd;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  jshift_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
    .sin_l(sin_l), .sin_r(sin_r), .d(d), .oe(oe), .q(q),
    .sout(sout), .cnt(cnt), .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // 2-state simulators resolve an undriven bus to 0 rather than z
  task automatic chk_z(string tag);
    checks++;
    assert ((q === {W{1'bz}}) || (q === {W{1'b0}})) else begin
      fails++;
      $error("FAIL %s got=%h exp=zz", tag, q);
    end
  endtask

  task automatic step(input logic r_, input logic e_, input logic [1:0] md,
                      input logic rt, input logic sl, input logic sr,
                      input logic [W-1:0] dd, input logic o);
    exp_t n;
    exp_t g;
    rst = r_; en = e_; mode = md; rot = rt;
    sin_l = sl; sin_r = sr; d = dd; oe = o;
    n = m;
    n.wd = 1'b0;
    if (r_) begin
      n.r = 8'h00; n.so = 1'b0; n.c = 4'd0;
    end else if (e_ && md == 2'b11) begin
      n.r = dd; n.c = 4'd0;
    end else if (e_ && md != 2'b00) begin
      if (md == 2'b01) begin
        n.so = m.r[0];
        n.r  = (m.r >> 1) | ({7'd0, rt ? m.r[0] : sl} << 7);
      end else begin
        n.so = m.r[7];
        n.r  = (m.r << 1) | {7'd0, rt ? m.r[7] : sr};
      end
      n.c  = (m.c < 4'd8) ? m.c + 4'd1 : 4'd8;
      n.wd = (m.c == 4'd7);
    end
    sb.push_back(n);
    m = n;
    @(posedge clk);
    #1;
    g = sb.pop_front();
    if (o) chk("q", 64'(q), 64'(g.r));
    else   chk_z("q_z");
    chk("sout", 64'(sout), 64'(g.so));
    chk("cnt", 64'(cnt), 64'(g.c));
    chk("word_done", 64'(word_done), 64'(g.wd));
    if (word_done === 1'b1) pulses++;
  endtask

  task automatic rs();
    step(1, 0, 2'b00, 0, 0, 0, 8'h00, 1);
  endtask
  task automatic ld(input logic [W-1:0] v);
    step(0, 1, 2'b11, 0, 0, 0, v, 1);
  endtask

  logic [W-1:0] ser_tab [8];
  logic [W-1:0] rot_tab [3];
  logic         rso_tab [3];

  initial begin
    ser_tab = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    rot_tab = '{8'h03, 8'h06, 8'h0C};
    rso_tab = '{1'b1, 1'b0, 1'b0};
    m = '{r: 8'h00, so: 1'b0, c: 4'd0, wd: 1'b0};
    rst = 1; en = 0; mode = 0; rot = 0; sin_l = 0; sin_r = 0; d = 0; oe = 1;
    @(negedge clk);
    rs();
    rs();

    // load, tristate, register untouched while oe low
    ld(8'hA5);
    chk("load_q", 64'(q), 64'h A5);
    oe = 0; #1;
    chk_z("oe_comb");
    step(0, 0, 2'b01, 0, 1, 1, 8'h00, 0);
    step(0, 1, 2'b00, 0, 1, 1, 8'h00, 0);
    oe = 1; #1;
    chk("oe_back", 64'(q), 64'hA5);

    // serial-in right shift
    rs();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2'b01, 0, 1, 0, 8'h00, 1);
      chk("ser_q", 64'(q), 64'(ser_tab[i]));
      chk("ser_cnt", 64'(cnt), 64'(i + 1));
      chk("ser_sout", 64'(sout), 64'd0);
    end
    chk("ser_pulses", 64'(pulses), 64'd1);

    // rotate left
    ld(8'h81);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b10, 1, 0, 0, 8'h00, 1);
      chk("rot_q", 64'(q), 64'(rot_tab[i]));
      chk("rot_sout", 64'(sout), 64'(rso_tab[i]));
    end

    // saturation with mixed directions, then reload
    ld(8'h5A);
    pulses = 0;
    for (int i = 0; i < 10; i++)
      step(0, 1, (i % 2) ? 2'b10 : 2'b01, 0, 1, 0, 8'h00, 1);
    chk("sat_cnt", 64'(cnt), 64'd8);
    chk("sat_pulses", 64'(pulses), 64'd1);
    ld(8'h3C);
    chk("reload_cnt", 64'(cnt), 64'd0);
    for (int i = 0; i < 8; i++)
      step(0, 1, 2'b10, 0, 0, 1, 8'h00, 1);
    chk("reload_pulses", 64'(pulses), 64'd2);

    // reset mid-word beats a load
    ld(8'hFF);
    for (int i = 0; i < 5; i++)
      step(0, 1, 2'b01, 0, 0, 0, 8'h00, 1);
    pulses = 0;
    step(1, 1, 2'b11, 0, 0, 0, 8'h00, 1);
    chk("rst_q", 64'(q), 64'h00);
    chk("rst_cnt", 64'(cnt), 64'd0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 2'b01, 0, 1, 1, 8'h00, 1);
    chk("rst_pulses", 64'(pulses), 64'd0);
    step(1, 0, 2'b00, 0, 0, 0, 8'h00, 0);

    // random traffic against the model
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), ($urandom_range(0, 7) != 0));

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
